// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of N signed 2W-bit products; define PRODUCT_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
// Latency: result is presented the cycle after the Nth accepted product; one group per N+1 cycles at best.
// Backpressure: in_ready drops while a result waits for out_ready; clear aborts the group and drops any pending result.
module product_accumulator #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [2*W-1:0] product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*W-1:0] result,
    output logic                  ovf
);
    localparam int AW = 2 * W;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_CNT = CW'(N);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic signed [AW-1:0] r_acc;
    logic [CW-1:0]        r_count;
    logic                 r_ovf;

    logic                 w_xfer;
    logic                 w_out_xfer;
    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] w_acc_nxt;
    logic                 w_sum_ovf;
    logic [CW-1:0]        w_count_inc;

    assign w_sum       = r_acc + product;
    assign w_sum_ovf   = (r_acc[AW-1] == product[AW-1]) && (w_sum[AW-1] != r_acc[AW-1]);
    assign w_count_inc = r_count + 1'b1;

`ifdef PRODUCT_ACC_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_POS = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_NEG = {1'b1, {(AW-1){1'b0}}};

    // Overflow can only happen when both operands share a sign, so that sign picks the rail.
    assign w_acc_nxt = !w_sum_ovf ? w_sum : (r_acc[AW-1] ? SAT_NEG : SAT_POS);
`else
    assign w_acc_nxt = w_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_xfer      = 1'b0;
        w_out_xfer  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_xfer   = in_valid && !clear;
                if (w_xfer) begin
                    w_state_nxt = (N == 1) ? DONE : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                w_xfer   = in_valid && !clear;
                if (w_xfer && (w_count_inc == N_CNT)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid  = 1'b1;
                w_out_xfer = out_ready;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // clear overrides every other input, including a pending result
        if (clear) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clear || w_out_xfer) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_xfer) begin
            if (r_state == IDLE) begin
                r_acc   <= product;
                r_count <= CW'(1);
                r_ovf   <= 1'b0;
            end else begin
                r_acc   <= w_acc_nxt;
                r_count <= w_count_inc;
                if (w_sum_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign result = r_acc;
    assign ovf    = r_ovf;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter W, default 32: multiplier operand width; products and result are 2*W bits.
REQ-002 SHALL have parameter N, default 4: products per group (dot-product length), N >= 1.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port clear, input, 1: synchronous group abort.
REQ-006 SHALL have port in_valid, input, 1: product presented.
REQ-007 SHALL have port in_ready, output, 1: block accepts product this cycle.
REQ-008 SHALL have port product, input, 2*W, signed: product from the upstream tree_multiplier.
REQ-009 SHALL have port out_valid, output, 1: group result held.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-011 SHALL have port result, output, 2*W, signed: accumulated group sum.
REQ-012 SHALL have port ovf, output, 1: signed overflow occurred in the current group.

Function
REQ-013 SHALL implement FSM states IDLE, ACC, DONE.
REQ-014 Transfer SHALL occur only on in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACC, 0 in DONE.
REQ-015 IDLE, on transfer: acc <= product, count <= 1, ovf <= 0; next state ACC, or DONE if N == 1.
REQ-016 ACC, on transfer: acc <= acc + product (2*W-bit signed), count <= count + 1; next state DONE when the new count equals N, else stay in ACC.
REQ-017 No transfer in IDLE/ACC SHALL leave acc, count, and ovf unchanged; gaps in in_valid are allowed.
REQ-018 Signed overflow SHALL be detected as: operand signs equal and sum sign differs; on detection ovf SHALL be set and remain set until the group ends.
REQ-019 DONE: out_valid = 1, result = acc, ovf held stable; on out_ready, next state IDLE with acc, count, and ovf cleared.
REQ-020 result and ovf SHALL NOT change while out_valid = 1 and out_ready = 0.
REQ-021 out_valid SHALL rise in the cycle after the Nth transfer; minimum period is N+1 cycles per group.
REQ-022 No product SHALL be accepted in the cycle that out_ready completes the output transfer.
REQ-023 clear = 1 SHALL have priority over all other inputs: next state IDLE, with acc, count, and ovf set to 0; a product presented in the same cycle SHALL be discarded, and a pending result SHALL be dropped.
REQ-024 count SHALL be clog2(N+1) bits wide, and it SHALL never exceed N.

Reset
REQ-025 rst SHALL asynchronously force state to IDLE and acc, count, and ovf to 0, so that in_ready = 1, out_valid = 0, result = 0, and ovf = 0.
REQ-026 Reset asserted mid-group or during DONE SHALL discard all partial or pending data, and no output transfer SHALL follow.
REQ-027 After rst deasserts, the first rising edge SHALL be able to accept a product.

Configuration
REQ-028 The macro PRODUCT_ACC_SATURATE_EN SHALL control overflow handling.
REQ-029 With PRODUCT_ACC_SATURATE_EN defined, on overflow acc SHALL clamp to +(2^(2W-1))-1 for positive overflow or -(2^(2W-1)) for negative overflow.
REQ-030 With PRODUCT_ACC_SATURATE_EN defined, accumulation after clamping SHALL continue from the clamped value.
REQ-031 Without PRODUCT_ACC_SATURATE_EN, acc SHALL wrap modulo 2^(2W).
REQ-032 ovf SHALL be reported in both builds.

Verification
REQ-033 W=32, N=4: products 6, -10, 100, 4, back-to-back, out_ready = 1 -> out_valid in the cycle after the 4th transfer, result = 100, ovf = 0, and the block returns to IDLE.
REQ-034 Same group with in_valid gaps and out_ready held 0 for 5 cycles -> in_ready = 0 throughout DONE, result stable at 100, and the transfer occurs when out_ready rises.
REQ-035 Products 0x7FFFFFFFFFFFFFFF, 1, 0, 0 -> ovf = 1; result = 0x7FFFFFFFFFFFFFFF with SATURATE_EN, 0x8000000000000000 without.
REQ-036 clear asserted with the 3rd product presented -> that product is discarded, state is IDLE, and the next group 1, 2, 3, 4 gives result = 10.
REQ-037 rst pulsed asynchronously between edges mid-group -> outputs return to reset values immediately, and the next group 5, 5, 5, 5 gives result = 20.
REQ-038 N=1: product -7 -> out_valid in the next cycle, result = -7.
